// File: rtl/disp_pkg.sv
// disp_pkg: shared types, constants and helpers for the display scan controller.
// Contents: state_t (BLANK, SHOW), SEG_OFF blank segment code, onehot() index decoder.
package disp_pkg;

    typedef enum logic {BLANK, SHOW} state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Decodes an index into a 32-bit one-hot word; callers truncate to their width.
    function automatic logic [31:0] onehot(input logic [31:0] i);
        return 32'd1 << i;
    endfunction

endpackage

// File: rtl/disp_blink_gen.sv
// disp_blink_gen: counts scan frames and toggles the blink phase every BLINK_FRAMES frames.
// Ports: clk, rst_n (async active-low), tick (frame-end pulse), phase (1 = blinked digits dark).
module disp_blink_gen #(
    parameter int BLINK_FRAMES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic phase
);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;
    logic          wrap;

    always_comb begin
        wrap    = frm_q == FW'(BLINK_FRAMES - 1);
        frm_d   = tick ? (wrap ? '0 : frm_q + 1'b1) : frm_q;
        phase_d = phase_q ^ (tick & wrap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed 7-segment scan with per-slot blanking dead-time and optional blink.
// Ports: clk, rst_n (async active-low), seg_in (DIGIT_CNT*7 packed codes), digit_en, blink_mask,
//        seg_out (registered segment bus), dig_sel (registered one-hot select), frame_tick (frame-end pulse).
// Build option: DISP_SCAN_BLINK_EN enables the blink phase generator; otherwise blink_mask is ignored.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGIT_CNT    = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIGIT_CNT*7-1:0] seg_in,
    input  logic [DIGIT_CNT-1:0]   digit_en,
    input  logic [DIGIT_CNT-1:0]   blink_mask,
    output logic [6:0]             seg_out,
    output logic [DIGIT_CNT-1:0]   dig_sel,
    output logic                   frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGIT_CNT);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [6:0]             seg_q, seg_d;
    logic [6:0]             seg_out_q, seg_out_d;
    logic [DIGIT_CNT-1:0]   dig_sel_q, dig_sel_d;
    logic                   frame_tick_q, frame_tick_d;
    logic                   slot_end, last_idx, show, phase;
    logic [6:0]             seg_pick;

    assign slot_end     = cnt_q == CW'(SCAN_DIV - 1);
    assign last_idx     = idx_q == IW'(DIGIT_CNT - 1);
    assign frame_tick_d = (state_q == SHOW) && slot_end && last_idx;

`ifdef DISP_SCAN_BLINK_EN
    disp_blink_gen #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (frame_tick_d),
        .phase (phase)
    );
`else
    assign phase = 1'b0;
`endif

    always_comb begin
        seg_pick = SEG_OFF;
        for (int i = 0; i < DIGIT_CNT; i++)
            if (idx_q == IW'(i)) seg_pick = seg_in[i*7 +: 7];
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        if (state_q == BLANK) begin
            // Segment code is captured once, at the end of the dead-time.
            if (cnt_q == CW'(BLANK_CYC - 1)) begin
                seg_d   = seg_pick;
                state_d = SHOW;
            end
        end else if (slot_end) begin
            state_d = BLANK;
            idx_d   = last_idx ? '0 : idx_q + 1'b1;
        end
        // Enable and blink gating act on the live inputs, so they can darken a digit mid-slot.
        show      = (state_q == SHOW) && digit_en[idx_q] && !(phase && blink_mask[idx_q]);
        seg_out_d = show ? seg_q : SEG_OFF;
        dig_sel_d = show ? DIGIT_CNT'(onehot(32'(idx_q))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_q        <= SEG_OFF;
            seg_out_q    <= SEG_OFF;
            dig_sel_q    <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            seg_out_q    <= seg_out_d;
            dig_sel_q    <= dig_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign dig_sel    = dig_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: self-checking bench for disp_scan_ctrl against a time-indexed reference model.
module tb_disp_scan_ctrl;

    localparam int N  = 3;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BF = 2;
`ifdef DISP_SCAN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N*7-1:0] seg_in;
    logic [N-1:0]  digit_en, blink_mask;
    logic [6:0]    seg_out;
    logic [N-1:0]  dig_sel;
    logic          frame_tick;

    disp_scan_ctrl #(
        .DIGIT_CNT(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    logic [6:0] smp [N];

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic [6:0] seg;
        logic       tick;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, t);
        end
    endtask

    // Advances one clock; expectation is derived from absolute time since reset release.
    task automatic step();
        int tn, s, off, dig, frm;
        logic ph, sh;
        logic [2:0] esel;
        logic [6:0] eseg;
        logic etick;
        tn  = t + 1;
        s   = (tn - 1) / SD;
        off = (tn - 1) % SD;
        dig = s % N;
        frm = s / N;
        ph  = BLINK && (((frm / BF) % 2) == 1);
        if (off == BC - 1) smp[dig] = seg_in[dig*7 +: 7];
        sh    = (off >= BC) && digit_en[dig] && !(ph && blink_mask[dig]);
        esel  = sh ? (3'b001 << dig) : 3'b000;
        eseg  = sh ? smp[dig] : 7'h00;
        etick = (off == SD - 1) && (dig == N - 1);
        @(posedge clk);
        t = tn;
        #1;
        chk("model_sel", 32'(dig_sel), 32'(esel));
        chk("model_seg", 32'(seg_out), 32'(eseg));
        chk("model_tick", 32'(frame_tick), 32'(etick));
        chk("onehot0", 32'($onehot0(dig_sel)), 1);
        chk("dark_seg", 32'((dig_sel == 0) && (seg_out != 0)), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg_out), 0);
        chk("rst_sel", 32'(dig_sel), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_sel", 32'(dig_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
    endtask

    initial begin
        int lit;
        int dark02;
        logic lit1 [6];
        vt[0]  = '{2,  3'b000, 7'h00, 1'b0};
        vt[1]  = '{3,  3'b001, 7'h06, 1'b0};
        vt[2]  = '{8,  3'b001, 7'h06, 1'b0};
        vt[3]  = '{9,  3'b000, 7'h00, 1'b0};
        vt[4]  = '{10, 3'b000, 7'h00, 1'b0};
        vt[5]  = '{11, 3'b010, 7'h5B, 1'b0};
        vt[6]  = '{16, 3'b010, 7'h5B, 1'b0};
        vt[7]  = '{17, 3'b000, 7'h00, 1'b0};
        vt[8]  = '{19, 3'b100, 7'h4F, 1'b0};
        vt[9]  = '{23, 3'b100, 7'h4F, 1'b0};
        vt[10] = '{24, 3'b100, 7'h4F, 1'b1};
        vt[11] = '{25, 3'b000, 7'h00, 1'b0};

        seg_in     = {7'h4F, 7'h5B, 7'h06};
        digit_en   = 3'b111;
        blink_mask = 3'b000;
        @(posedge clk);
        do_reset();

        // Scan order, with digit 0 rewritten mid-slot at cycle 5.
        foreach (vt[i]) begin
            while (t < vt[i].cyc) begin
                step();
                if (t == 5) seg_in[6:0] = 7'h3F;
            end
            chk($sformatf("tbl_sel_c%0d", vt[i].cyc), 32'(dig_sel), 32'(vt[i].sel));
            chk($sformatf("tbl_seg_c%0d", vt[i].cyc), 32'(seg_out), 32'(vt[i].seg));
            chk($sformatf("tbl_tick_c%0d", vt[i].cyc), 32'(frame_tick), 32'(vt[i].tick));
        end
        while (t < 32) begin
            step();
            if (t >= 27) begin
                chk("mid_upd_seg", 32'(seg_out), 32'h3F);
                chk("mid_upd_sel", 32'(dig_sel), 32'h1);
            end
        end

        // Digit 1 disabled for a whole frame.
        while (t < 48) step();
        digit_en = 3'b101;
        lit = 0;
        while (t < 72) begin
            step();
            if (t >= 57 && t <= 64 && (dig_sel != 0 || seg_out != 0)) lit++;
            if (t == 51) chk("en_d0_sel", 32'(dig_sel), 32'h1);
            if (t == 67) chk("en_d2_seg", 32'(seg_out), 32'h4F);
        end
        chk("en_d1_dark", lit, 0);
        digit_en = 3'b111;

        // Async reset while digit 1 is showing.
        do_reset();
        while (t < 13) step();
        chk("pre_rst_sel", 32'(dig_sel), 32'h2);
        do_reset();
        while (t < 3) begin
            step();
            if (t == 2) chk("post_rst_blank", 32'(dig_sel), 0);
        end
        chk("post_rst_d0", 32'(dig_sel), 32'h1);

        // Blink on digit 1 over six frames.
        blink_mask = 3'b010;
        foreach (lit1[f]) lit1[f] = 1'b0;
        dark02 = 0;
        while (t < 144) begin
            step();
            if (dig_sel[1]) lit1[(t - 1) / 24] = 1'b1;
            if (((t - 1) % SD) >= BC && (((t - 1) / SD) % N) != 1 && dig_sel == 0) dark02++;
        end
        foreach (lit1[f])
            chk($sformatf("blink_d1_f%0d", f), 32'(lit1[f]), 32'(!(BLINK && (f == 2 || f == 3))));
        chk("blink_d02_lit", dark02, 0);

        // Ten frames of random stimulus against the model.
        repeat (10 * N * SD) begin
            seg_in = 21'($urandom);
            if ($urandom_range(7) == 0) digit_en = 3'($urandom);
            if ($urandom_range(7) == 0) blink_mask = 3'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the multi-digit 7-segment display. It takes the packed per-digit segment codes produced by the binary-to-BCD display path and drives one shared 7-bit segment bus plus a one-hot digit-select bus. It inserts a blanking dead-time between digits to suppress ghosting and optionally blinks selected digits, for example the field being edited in clock set mode. It sits between the display datapath and the board pins.

## Interface
- DIGIT_CNT, 6, number of digits scanned (≥2).
- SCAN_DIV, 50000, clock cycles per digit slot, blank time included.
- BLANK_CYC, 500, dead-time cycles at the start of each slot (1 ≤ BLANK_CYC < SCAN_DIV).
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1).
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  DIGIT_CNT*7  packed segment codes; digit i at [i*7 +: 7]; 1 = segment lit.
- digit_en  input  DIGIT_CNT  per-digit enable; 0 forces that digit dark for its slot. The slot is still consumed.
- blink_mask  input  DIGIT_CNT  per-digit blink request.
- seg_out  output  7  shared segment bus, active high, registered.
- dig_sel  output  DIGIT_CNT  one-hot digit select, active high, registered; all-zero during blanking.
- frame_tick  output  1  one-cycle pulse on the cycle digit DIGIT_CNT-1's slot ends.

## Operation
- States: BLANK, SHOW.
- Registers: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..DIGIT_CNT-1), latched segment register seg_q, blink phase bit, frame counter (0..BLINK_FRAMES-1).
- Reset values: state=BLANK, cnt=0, idx=0, seg_out=0, dig_sel=0, frame_tick=0, phase=0, frame counter=0.
- BLANK: dig_sel=0, seg_out=0.
  - When cnt reaches BLANK_CYC-1: sample seg_in[idx*7 +: 7] into seg_q and go to SHOW.
- SHOW: seg_out=seg_q and dig_sel=onehot(idx), both gated to zero when digit_en[idx]=0 or when (phase=1 and blink_mask[idx]=1).
  - When cnt reaches SCAN_DIV-1: cnt←0 and go to BLANK.
  - Also idx←idx+1, wrapping DIGIT_CNT-1→0.
- cnt increments every cycle and clears only at the slot end.
- Wrap to idx=0 is a frame boundary:
  - Pulse frame_tick.
  - Increment the frame counter. When it wraps from BLINK_FRAMES-1, toggle phase.
- digit_en and blink_mask are evaluated combinationally every cycle of SHOW, before the output register. A change takes effect on the next cycle.
- seg_in is sampled only once per slot. Mid-slot changes do not appear until that digit's next slot.
- dig_sel never has more than one bit set. seg_out is zero whenever dig_sel is zero.

## Timing
- First rising edge after rst_n deasserts is cycle 1.
- Cycles 1..BLANK_CYC: dig_sel=0.
- Cycles BLANK_CYC+1..SCAN_DIV: digit 0 shown.
- Each following slot is offset by SCAN_DIV cycles.
- Frame period = DIGIT_CNT*SCAN_DIV cycles.
- Blink half-period = BLINK_FRAMES frames.
- Latency seg_in → seg_out: one cycle from the sampling edge.
- Reset asserted mid-slot: all outputs go to zero immediately (asynchronous). Scanning restarts from idx=0 in BLANK.

## Configuration
- DISP_SCAN_BLINK_EN defined:
  - Blink phase and frame counter are implemented as described.
- DISP_SCAN_BLINK_EN undefined:
  - Phase is tied to 0 and the frame counter is removed.
  - blink_mask remains a port but is ignored.
  - frame_tick is still generated.

## Structure
- Shared package disp_pkg holds:
  - the state typedef (BLANK, SHOW);
  - constant SEG_OFF = 7'b0000000;
  - a helper function for one-hot decode of idx.
- One natural sub-module: disp_blink_gen. It counts frame_tick pulses and outputs phase. It is instantiated only under DISP_SCAN_BLINK_EN.

## Test plan
Bench parameters: DIGIT_CNT=3, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
- Reset and scan order, with seg_in = {7'h4F, 7'h5B, 7'h06}, all enabled:
  - cycles 1-2: dig_sel=000;
  - cycles 3-8: dig_sel=001, seg_out=06;
  - cycles 9-10: blank;
  - cycles 11-16: 010/5B;
  - cycles 19-24: 100/4F;
  - frame_tick high on cycle 24 only.
- Mid-slot update: change digit 0 to 7'h3F at cycle 5 → seg_out stays 06 through cycle 8 and shows 3F in cycles 27-32.
- digit_en=3'b101 → dig_sel and seg_out are zero for the entire digit-1 slot. Digits 0 and 2 are unchanged.
- Blink (macro defined), blink_mask=3'b010 → digit 1 lit in frames 0-1, dark in frames 2-3, lit again in frames 4-5. Digits 0 and 2 are never dark. Without the macro, digit 1 is never dark.
- Async reset pulsed at cycle 13 (digit 1 showing) → outputs zero the same cycle. After release, digit 0 is shown again after 2 blank cycles.
- Over 10 frames: dig_sel is always one-hot or zero, and seg_out≠0 never occurs while dig_sel=0.
